// File: rtl/sad_pkg.sv
// Shared definitions for the SAD address generator: walker FSM encoding and default widths.
package sad_pkg;

   localparam int SAD_ADDR_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sad_state_e;

endpackage

// File: rtl/sad_addr_gen_if.sv
// Address stream from the SAD window walker to the SAD memory port (valid/ready).
interface sad_addr_gen_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 8
);

   logic [ADDR_W-1:0] addr;
   logic              addr_valid;
   logic              addr_ready;
   logic [CNT_W-1:0]  row_idx;
   logic [CNT_W-1:0]  col_idx;
   logic              last;

   modport master (
      output addr, addr_valid, row_idx, col_idx, last,
      input  addr_ready
   );

   modport slave (
      input  addr, addr_valid, row_idx, col_idx, last,
      output addr_ready
   );

endinterface

// File: rtl/sad_ofs_table.sv
// NUM_OFS x ADDR_W offset register file: one write port, one async read port, sync active-low clear.
module sad_ofs_table #(
   parameter int ADDR_W  = 32,
   parameter int NUM_OFS = 4,
   parameter int SEL_W   = $clog2(NUM_OFS)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              wr_en,
   input  logic [SEL_W-1:0]  wr_idx,
   input  logic [ADDR_W-1:0] wr_data,
   input  logic [SEL_W-1:0]  rd_idx,
   output logic [ADDR_W-1:0] rd_data
);

   logic [ADDR_W-1:0] mem_q [NUM_OFS];
   logic [ADDR_W-1:0] mem_d [NUM_OFS];

   always_comb begin
      for (int i = 0; i < NUM_OFS; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr_en && (int'(wr_idx) < NUM_OFS)) begin
         mem_d[wr_idx] = wr_data;
      end
   end

   always_ff @(posedge Clk) begin
      for (int i = 0; i < NUM_OFS; i++) begin
         if (!Rst) begin
            mem_q[i] <= '0;
         end else begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Out-of-range selectors (non power-of-two tables) read as a zero offset.
   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < NUM_OFS) begin
         rd_data = mem_q[rd_idx];
      end
   end

endmodule

// File: rtl/sad_addr_gen.sv
// SAD window address generator: base+offset[sel] latched on start, then a rows x cols walk.
// Optional `define SAD_AG_BOUND_EN adds the limit input and advisory oob output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; no address presented
// ST_RUN  | addr_valid high, one address per accepted beat
// ST_DONE | single-cycle completion, done pulse
module sad_addr_gen
   import sad_pkg::*;
#(
   parameter int ADDR_W  = SAD_ADDR_W,
   parameter int NUM_OFS = 4,
   parameter int CNT_W   = 8,
   parameter int SEL_W   = $clog2(NUM_OFS)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              ofs_wr_en,
   input  logic [SEL_W-1:0]  ofs_wr_idx,
   input  logic [ADDR_W-1:0] ofs_wr_data,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [SEL_W-1:0]  sel,
   input  logic [CNT_W-1:0]  rows,
   input  logic [CNT_W-1:0]  cols,
   input  logic [ADDR_W-1:0] stride,
   sad_addr_gen_if.master    ag,
`ifdef SAD_AG_BOUND_EN
   input  logic [ADDR_W-1:0] limit,
   output logic              oob,
`endif
   output logic              busy,
   output logic              done
);

   sad_state_e        state_q, state_d;
   logic [ADDR_W-1:0] rb_q, rb_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [CNT_W-1:0]  rows_q, rows_d;
   logic [CNT_W-1:0]  cols_q, cols_d;
   logic [CNT_W-1:0]  row_q, row_d;
   logic [CNT_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] ofs_rd;
   logic              last_col;
   logic              last_row;

   // Async read: a write landing on the same edge as start is not yet visible.
   sad_ofs_table #(
      .ADDR_W  (ADDR_W),
      .NUM_OFS (NUM_OFS),
      .SEL_W   (SEL_W)
   ) u_ofs_table (
      .Clk     (Clk),
      .Rst     (Rst),
      .wr_en   (ofs_wr_en),
      .wr_idx  (ofs_wr_idx),
      .wr_data (ofs_wr_data),
      .rd_idx  (sel),
      .rd_data (ofs_rd)
   );

   assign last_col = (col_q == cols_q - CNT_W'(1));
   assign last_row = (row_q == rows_q - CNT_W'(1));

   always_comb begin
      state_d  = state_q;
      rb_d     = rb_q;
      stride_d = stride_q;
      rows_d   = rows_q;
      cols_d   = cols_q;
      row_d    = row_q;
      col_d    = col_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rb_d     = base + ofs_rd;
               stride_d = stride;
               rows_d   = rows;
               cols_d   = cols;
               row_d    = '0;
               col_d    = '0;
               state_d  = ((rows == '0) || (cols == '0)) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (ag.addr_ready) begin
               if (last_row && last_col) begin
                  state_d = ST_DONE;
               end
               if (!last_col) begin
                  col_d = col_q + CNT_W'(1);
               end else begin
                  col_d = '0;
                  row_d = row_q + CNT_W'(1);
                  rb_d  = rb_q + stride_q;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q  <= ST_IDLE;
         rb_q     <= '0;
         stride_q <= '0;
         rows_q   <= '0;
         cols_q   <= '0;
         row_q    <= '0;
         col_q    <= '0;
      end else begin
         state_q  <= state_d;
         rb_q     <= rb_d;
         stride_q <= stride_d;
         rows_q   <= rows_d;
         cols_q   <= cols_d;
         row_q    <= row_d;
         col_q    <= col_d;
      end
   end

   assign ag.addr_valid = (state_q == ST_RUN);
   assign ag.addr       = rb_q + ADDR_W'(col_q);
   assign ag.row_idx    = row_q;
   assign ag.col_idx    = col_q;
   assign ag.last       = ag.addr_valid && last_row && last_col;
   assign busy          = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign done          = (state_q == ST_DONE);

`ifdef SAD_AG_BOUND_EN
   // Advisory only: the walk continues past the bound.
   assign oob = ag.addr_valid && (ag.addr >= limit);
`endif

endmodule

// File: tb/tb_sad_addr_gen.sv
// Directed, table-driven bench for sad_addr_gen; extra oob check when SAD_AG_BOUND_EN is defined.
module tb_sad_addr_gen;

   typedef struct {
      logic        rdy;
      logic        v;
      logic [31:0] a;
      logic [7:0]  r;
      logic [7:0]  c;
      logic        l;
      logic        b;
      logic        d;
   } vec_t;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        ofs_wr_en;
   logic [1:0]  ofs_wr_idx;
   logic [31:0] ofs_wr_data;
   logic        start;
   logic [31:0] base;
   logic [1:0]  sel;
   logic [7:0]  rows;
   logic [7:0]  cols;
   logic [31:0] stride;
   logic        busy;
   logic        done;
`ifdef SAD_AG_BOUND_EN
   logic [31:0] limit;
   logic        oob;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   vec_t vq[$];

   sad_addr_gen_if #(.ADDR_W(32), .CNT_W(8)) ag_if ();

   sad_addr_gen #(.ADDR_W(32), .NUM_OFS(4), .CNT_W(8)) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .ofs_wr_en   (ofs_wr_en),
      .ofs_wr_idx  (ofs_wr_idx),
      .ofs_wr_data (ofs_wr_data),
      .start       (start),
      .base        (base),
      .sel         (sel),
      .rows        (rows),
      .cols        (cols),
      .stride      (stride),
      .ag          (ag_if),
`ifdef SAD_AG_BOUND_EN
      .limit       (limit),
      .oob         (oob),
`endif
      .busy        (busy),
      .done        (done)
   );

   always #5 Clk = ~Clk;

   function automatic vec_t mk(input logic rdy, input logic v, input logic [31:0] a,
                               input logic [7:0] r, input logic [7:0] c,
                               input logic l, input logic b, input logic d);
      vec_t x;
      x.rdy = rdy; x.v = v; x.a = a; x.r = r; x.c = c; x.l = l; x.b = b; x.d = d;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Called at a falling edge: checks outputs, drives ready for the next rising edge.
   task automatic run_vecs(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         chk($sformatf("v%0d valid", i), 32'(ag_if.addr_valid), 32'(vq[i].v));
         chk($sformatf("v%0d last", i),  32'(ag_if.last),       32'(vq[i].l));
         chk($sformatf("v%0d busy", i),  32'(busy),             32'(vq[i].b));
         chk($sformatf("v%0d done", i),  32'(done),             32'(vq[i].d));
         if (vq[i].v) begin
            chk($sformatf("v%0d addr", i), ag_if.addr,          vq[i].a);
            chk($sformatf("v%0d row", i),  32'(ag_if.row_idx),  32'(vq[i].r));
            chk($sformatf("v%0d col", i),  32'(ag_if.col_idx),  32'(vq[i].c));
         end
         ag_if.addr_ready = vq[i].rdy;
         @(negedge Clk);
      end
   endtask

   task automatic do_start(input logic [31:0] b, input logic [1:0] s, input logic [7:0] r,
                           input logic [7:0] c, input logic [31:0] st);
      start = 1'b1; base = b; sel = s; rows = r; cols = c; stride = st;
      @(negedge Clk);
      start = 1'b0;
   endtask

   task automatic wr_ofs(input logic [1:0] idx, input logic [31:0] data);
      ofs_wr_en = 1'b1; ofs_wr_idx = idx; ofs_wr_data = data;
      @(negedge Clk);
      ofs_wr_en = 1'b0;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, " valid"}, 32'(ag_if.addr_valid), 32'd0);
      chk({tag, " addr"},  ag_if.addr,            32'd0);
      chk({tag, " row"},   32'(ag_if.row_idx),    32'd0);
      chk({tag, " col"},   32'(ag_if.col_idx),    32'd0);
      chk({tag, " last"},  32'(ag_if.last),       32'd0);
      chk({tag, " busy"},  32'(busy),             32'd0);
      chk({tag, " done"},  32'(done),             32'd0);
   endtask

   int t1, t2, t3, t4, t5, t6a, t6b;

   initial begin
      // walk 1: 2x3 window, ready always high
      t1 = vq.size();
      vq.push_back(mk(1, 1, 32'h1100, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h1101, 0, 1, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h1102, 0, 2, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h1140, 1, 0, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h1141, 1, 1, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h1142, 1, 2, 1, 1, 0));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 1, 1));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 0, 0));
      // same walk, ready 1-0-0 repeating
      t2 = vq.size();
      vq.push_back(mk(1, 1, 32'h1100, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 1, 32'h1101, 0, 1, 0, 1, 0));
      vq.push_back(mk(0, 1, 32'h1101, 0, 1, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h1101, 0, 1, 0, 1, 0));
      vq.push_back(mk(0, 1, 32'h1102, 0, 2, 0, 1, 0));
      vq.push_back(mk(0, 1, 32'h1102, 0, 2, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h1102, 0, 2, 0, 1, 0));
      vq.push_back(mk(0, 1, 32'h1140, 1, 0, 0, 1, 0));
      vq.push_back(mk(0, 1, 32'h1140, 1, 0, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h1140, 1, 0, 0, 1, 0));
      vq.push_back(mk(0, 1, 32'h1141, 1, 1, 0, 1, 0));
      vq.push_back(mk(0, 1, 32'h1141, 1, 1, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h1141, 1, 1, 0, 1, 0));
      vq.push_back(mk(0, 1, 32'h1142, 1, 2, 1, 1, 0));
      vq.push_back(mk(0, 1, 32'h1142, 1, 2, 1, 1, 0));
      vq.push_back(mk(1, 1, 32'h1142, 1, 2, 1, 1, 0));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 1, 1));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 0, 0));
      // empty window
      t3 = vq.size();
      vq.push_back(mk(1, 0, 32'h0, 0, 0, 0, 1, 1));
      vq.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0, 0));
      vq.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0, 0));
      // address wrap at 2^32
      t4 = vq.size();
      vq.push_back(mk(1, 1, 32'hFFFF_FFFE, 0, 0, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'hFFFF_FFFF, 0, 1, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h0000_0000, 0, 2, 0, 1, 0));
      vq.push_back(mk(1, 1, 32'h0000_0001, 0, 3, 1, 1, 0));
      vq.push_back(mk(1, 0, 32'h0,         0, 0, 0, 1, 1));
      vq.push_back(mk(1, 0, 32'h0,         0, 0, 0, 0, 0));
      // single-beat walk after reset: table cleared so ofs[2] reads 0
      t5 = vq.size();
      vq.push_back(mk(1, 1, 32'h2000, 0, 0, 1, 1, 0));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 1, 1));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 0, 0));
      // write and start on the same edge: old then new offset
      t6a = vq.size();
      vq.push_back(mk(1, 1, 32'h3010, 0, 0, 1, 1, 0));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 1, 1));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 0, 0));
      t6b = vq.size();
      vq.push_back(mk(1, 1, 32'h3020, 0, 0, 1, 1, 0));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 1, 1));
      vq.push_back(mk(1, 0, 32'h0,    0, 0, 0, 0, 0));

      Rst = 1'b0; ofs_wr_en = 1'b0; ofs_wr_idx = '0; ofs_wr_data = '0;
      start = 1'b0; base = '0; sel = '0; rows = '0; cols = '0; stride = '0;
      ag_if.addr_ready = 1'b0;
`ifdef SAD_AG_BOUND_EN
      limit = 32'hFFFF_FFFF;
`endif
      repeat (3) @(negedge Clk);
      chk_idle_zero("reset");
      Rst = 1'b1;
      @(negedge Clk);

      wr_ofs(2'd2, 32'h100);
      do_start(32'h1000, 2'd2, 8'd2, 8'd3, 32'h40);
      run_vecs(t1, 8);

      do_start(32'h1000, 2'd2, 8'd2, 8'd3, 32'h40);
      run_vecs(t2, 18);

      do_start(32'h1000, 2'd2, 8'd0, 8'd3, 32'h40);
      run_vecs(t3, 3);

      // start while RUN must not disturb the walk in progress
      ag_if.addr_ready = 1'b0;
      do_start(32'h1000, 2'd2, 8'd1, 8'd2, 32'h40);
      chk("runstart addr0", ag_if.addr, 32'h1100);
      start = 1'b1; base = 32'h5000; sel = 2'd0; rows = 8'd0;
      @(negedge Clk);
      start = 1'b0;
      chk("runstart hold addr", ag_if.addr, 32'h1100);
      chk("runstart hold valid", 32'(ag_if.addr_valid), 32'd1);
      ag_if.addr_ready = 1'b1;
      @(negedge Clk);
      chk("runstart addr1", ag_if.addr, 32'h1101);
      chk("runstart last", 32'(ag_if.last), 32'd1);
      @(negedge Clk);
      chk("runstart done", 32'(done), 32'd1);
      @(negedge Clk);
      chk("runstart idle busy", 32'(busy), 32'd0);
      @(negedge Clk);
      chk("runstart no restart", 32'(ag_if.addr_valid), 32'd0);

      do_start(32'hFFFF_FFFE, 2'd0, 8'd1, 8'd4, 32'h40);
      run_vecs(t4, 6);

      wr_ofs(2'd1, 32'h10);
      ofs_wr_en = 1'b1; ofs_wr_idx = 2'd1; ofs_wr_data = 32'h20;
      do_start(32'h3000, 2'd1, 8'd1, 8'd1, 32'h0);
      ofs_wr_en = 1'b0;
      run_vecs(t6a, 3);
      do_start(32'h3000, 2'd1, 8'd1, 8'd1, 32'h0);
      run_vecs(t6b, 3);

      // reset after three accepted beats
      do_start(32'h1000, 2'd2, 8'd2, 8'd3, 32'h40);
      run_vecs(t1, 3);
      chk("prerst addr", ag_if.addr, 32'h1140);
      Rst = 1'b0;
      @(negedge Clk);
      chk_idle_zero("midrst");
      Rst = 1'b1;
      @(negedge Clk);
      chk("postrst done", 32'(done), 32'd0);
      chk("postrst valid", 32'(ag_if.addr_valid), 32'd0);
      do_start(32'h2000, 2'd2, 8'd1, 8'd1, 32'h40);
      run_vecs(t5, 3);

`ifdef SAD_AG_BOUND_EN
      begin
         logic [5:0] exp_oob;
         exp_oob = 6'b111100;
         limit = 32'h1102;
         wr_ofs(2'd2, 32'h100);
         do_start(32'h1000, 2'd2, 8'd2, 8'd3, 32'h40);
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("oob beat%0d", k), 32'(oob), 32'(exp_oob[k]));
            ag_if.addr_ready = 1'b1;
            @(negedge Clk);
         end
         chk("oob after walk", 32'(oob), 32'd0);
         @(negedge Clk);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
